// File: rtl/spimem_cache_pkg.sv
// Shared definitions for the spimemio read cache: bus widths, FSM states
// and the byte-address to index/tag split.
package spimem_cache_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  // Word index inside the cache; bits [1:0] select a byte and are dropped.
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                   input int idx_w);
    return (addr >> 2) & ((ADDR_W'(1) << idx_w) - ADDR_W'(1));
  endfunction

  // Everything above the index is the tag.
  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                 input int idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/spimem_cache_array.sv
// Tag/data storage for the direct-mapped cache: synchronous write,
// combinational read, per-entry valid bits that a flush clears in one edge.
module spimem_cache_array
  import spimem_cache_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data
);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [DATA_W-1:0]  data_mem [ENTRIES];

  // Flush beats a simultaneous fill, so a line written during a flush stays invalid.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Valid bits are the only storage that needs a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/spimem_cache.sv
// Direct-mapped, word-granular, read-only cache sitting between the CPU
// memory bus and spimemio. Hits answer one cycle after acceptance; misses
// run one spimemio read and answer one cycle after mem_ready.
// Optional hit/miss counters are built when SPIMEM_CACHE_STATS_EN is defined.
module spimem_cache
  import spimem_cache_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef SPIMEM_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  state_e            state_q, state_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              accept;
  logic              lookup_hit;
  logic              fetch_done;

  assign lk_idx = IDX_W'(addr_index(cpu_addr, IDX_W));
  assign lk_tag = TAG_W'(addr_tag(cpu_addr, IDX_W));

  // The cycle carrying cpu_ready never starts a lookup, so a held request is not replayed.
  assign accept     = (state_q == IDLE) && cpu_valid && !cpu_ready_q;
  assign lookup_hit = accept && rd_valid && (rd_tag == lk_tag) && !flush;
  assign fetch_done = (state_q == FETCH) && mem_ready;
  assign wr_en      = fetch_done;

  spimem_cache_array #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_idx   (IDX_W'(addr_index(mem_addr_q, IDX_W))),
    .wr_tag   (TAG_W'(addr_tag(mem_addr_q, IDX_W))),
    .wr_data  (mem_rdata),
    .rd_idx   (lk_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  // Lookup/fetch FSM; the fill address comes from mem_addr_q so a misbehaving CPU cannot corrupt it.
  always_comb begin
    state_d     = state_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    unique case (state_q)
      IDLE: begin
        if (lookup_hit) begin
          cpu_ready_d = 1'b1;
          cpu_rdata_d = rd_data;
        end else if (accept) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          cpu_ready_d = 1'b1;
          cpu_rdata_d = mem_rdata;
          mem_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and handshake registers; reset also drops an in-flight spimemio request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;

`ifdef SPIMEM_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Free-running wrap-around counters; flush deliberately leaves them alone.
  always_comb begin
    hit_count_d  = hit_count_q + (lookup_hit ? 32'd1 : 32'd0);
    miss_count_d = miss_count_q + (fetch_done ? 32'd1 : 32'd0);
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_spimem_cache.sv
// Self-checking bench for spimem_cache with ENTRIES=16: a directed table
// following the cold/hit/conflict/flush scenarios, a mid-fetch reset, then
// randomized reads checked against a simple direct-mapped cache model.
module tb_spimem_cache;

   localparam int ENTRIES = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        cpuValid;
   logic        cpuReady;
   logic [23:0] cpuAddr;
   logic [31:0] cpuRdata;
   logic        memValid;
   logic        memReady;
   logic [23:0] memAddr;
   logic [31:0] memRdata;
`ifdef SPIMEM_CACHE_STATS_EN
   logic [31:0] hitCount;
   logic [31:0] missCount;
`endif

   int totalChecks  = 0;
   int passedChecks = 0;
   int modelHits    = 0;
   int modelMisses  = 0;

   bit          modelValid [ENTRIES];
   int unsigned modelWord  [ENTRIES];

   typedef struct {
      logic [23:0] addr;
      int          latency;
      bit          flushBefore;
      bit          flushAtAccept;
      bit          flushAtMemReady;
      bit          expHit;
   } vector_t;

   vector_t vectors [12];

   spimem_cache #(.ENTRIES(ENTRIES)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .cpu_valid  (cpuValid),
      .cpu_ready  (cpuReady),
      .cpu_addr   (cpuAddr),
      .cpu_rdata  (cpuRdata),
      .mem_valid  (memValid),
      .mem_ready  (memReady),
      .mem_addr   (memAddr),
      .mem_rdata  (memRdata)
`ifdef SPIMEM_CACHE_STATS_EN
      ,
      .hit_count  (hitCount),
      .miss_count (missCount)
`endif
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Contents of the simulated flash: one fixed word, the rest a hash of the word address.
   function automatic logic [31:0] flashWord(input logic [23:0] addr);
      logic [31:0] word;
      word = {8'h00, addr[23:2], 2'b00};
      if (word == 32'h0010_0000) return 32'hDEAD_BEEF;
      return word * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction

   // Model prediction: a word is present if its slot holds that word and no flush races the lookup.
   function automatic bit modelPredict(input logic [23:0] addr, input bit flushAtAccept);
      int unsigned word;
      int idx;
      word = int'(addr) / 4;
      idx  = int'(word % ENTRIES);
      return !flushAtAccept && modelValid[idx] && (modelWord[idx] == word);
   endfunction

   // Clears every model slot, as a flush or reset does.
   task automatic modelClear();
      for (int i = 0; i < ENTRIES; i++) modelValid[i] = 1'b0;
   endtask

   // Applies the effect of one completed read to the model.
   task automatic modelCommit(input logic [23:0] addr, input bit wasHit,
                              input bit flushAtAccept, input bit flushAtMemReady);
      int unsigned word;
      int idx;
      word = int'(addr) / 4;
      idx  = int'(word % ENTRIES);
      if (flushAtAccept) modelClear();
      if (wasHit) begin
         modelHits++;
      end else begin
         modelMisses++;
         if (flushAtMemReady) begin
            modelClear();
         end else begin
            modelValid[idx] = 1'b1;
            modelWord[idx]  = word;
         end
      end
   endtask

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) begin
         passedChecks++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Issues one CPU read, plays spimemio for it, and checks latency, data and bus activity.
   task automatic applyStimulus(input logic [23:0] addr, input int latency,
                                input bit flushAtAccept, input bit flushAtMemReady,
                                input bit expHit);
      int cycles;
      int memWait;
      bit done;
      bit sawMem;
      logic [23:0] wordAddr;
      wordAddr = {addr[23:2], 2'b00};
      cycles   = 0;
      memWait  = 0;
      done     = 1'b0;
      sawMem   = 1'b0;
      @(negedge clk);
      cpuValid = 1'b1;
      cpuAddr  = addr;
      flush    = flushAtAccept;
      while (!done && cycles < 200) begin
         @(negedge clk);
         cycles++;
         flush    = 1'b0;
         memReady = 1'b0;
         if (cpuReady) begin
            done = 1'b1;
         end else if (memValid) begin
            if (!sawMem) begin
               sawMem = 1'b1;
               checkOutput("mem_addr", {8'h00, memAddr}, {8'h00, wordAddr});
            end
            if (memWait == latency) begin
               memReady = 1'b1;
               memRdata = flashWord(memAddr);
               flush    = flushAtMemReady;
            end else begin
               memWait++;
            end
         end
      end
      cpuValid = 1'b0;
      memReady = 1'b0;
      flush    = 1'b0;
      checkOutput("cpu_ready seen", 32'(done), 32'd1);
      checkOutput("latency", cycles, expHit ? 32'd1 : 32'(latency + 2));
      checkOutput("cpu_rdata", cpuRdata, flashWord(addr));
      checkOutput("mem request issued", 32'(sawMem), 32'(!expHit));
      @(negedge clk);
      checkOutput("cpu_ready single pulse", 32'(cpuReady), 32'd0);
      checkOutput("cpu_rdata held", cpuRdata, flashWord(addr));
      checkOutput("mem_valid idle", 32'(memValid), 32'd0);
      modelCommit(addr, expHit, flushAtAccept, flushAtMemReady);
`ifdef SPIMEM_CACHE_STATS_EN
      checkOutput("hit_count", hitCount, 32'(modelHits));
      checkOutput("miss_count", missCount, 32'(modelMisses));
`endif
   endtask

   initial begin
      vector_t v;
      logic [23:0] rAddr;
      int rLat;
      bit rFa;
      bit rFm;

      // Directed scenarios: cold miss, hits, conflicts, flushes.
      vectors[0]  = '{24'h100000, 40, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[1]  = '{24'h100000,  0, 1'b0, 1'b0, 1'b0, 1'b1};
      vectors[2]  = '{24'h100002,  0, 1'b0, 1'b0, 1'b0, 1'b1};
      vectors[3]  = '{24'h100040,  5, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[4]  = '{24'h100000,  3, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[5]  = '{24'h100040,  4, 1'b1, 1'b0, 1'b0, 1'b0};
      vectors[6]  = '{24'h100080,  2, 1'b0, 1'b0, 1'b1, 1'b0};
      vectors[7]  = '{24'h100080,  1, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[8]  = '{24'h100040,  2, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[9]  = '{24'h100040,  3, 1'b0, 1'b1, 1'b0, 1'b0};
      vectors[10] = '{24'h100044,  0, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[11] = '{24'h100047,  0, 1'b0, 1'b0, 1'b0, 1'b1};

      reset    = 1'b1;
      flush    = 1'b0;
      cpuValid = 1'b0;
      cpuAddr  = '0;
      memReady = 1'b0;
      memRdata = '0;
      modelClear();

      repeat (2) @(negedge clk);
      checkOutput("reset cpu_ready", 32'(cpuReady), 32'd0);
      checkOutput("reset cpu_rdata", cpuRdata, 32'd0);
      checkOutput("reset mem_valid", 32'(memValid), 32'd0);
      checkOutput("reset mem_addr", {8'h00, memAddr}, 32'd0);
`ifdef SPIMEM_CACHE_STATS_EN
      checkOutput("reset hit_count", hitCount, 32'd0);
      checkOutput("reset miss_count", missCount, 32'd0);
`endif
      reset = 1'b0;

      $display("[TB] directed table");
      for (int i = 0; i < 12; i++) begin
         v = vectors[i];
         if (v.flushBefore) begin
            @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            modelClear();
         end
         applyStimulus(v.addr, v.latency, v.flushAtAccept, v.flushAtMemReady, v.expHit);
      end

      $display("[TB] reset during fetch");
      @(negedge clk);
      cpuValid = 1'b1;
      cpuAddr  = 24'h100040;
      flush    = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("mem_valid during fetch", 32'(memValid), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async reset mem_valid", 32'(memValid), 32'd0);
      checkOutput("async reset cpu_ready", 32'(cpuReady), 32'd0);
      checkOutput("async reset cpu_rdata", cpuRdata, 32'd0);
`ifdef SPIMEM_CACHE_STATS_EN
      checkOutput("async reset hit_count", hitCount, 32'd0);
      checkOutput("async reset miss_count", missCount, 32'd0);
`endif
      cpuValid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      modelClear();
      modelHits   = 0;
      modelMisses = 0;
      applyStimulus(24'h100040, 2, 1'b0, 1'b0, 1'b0);

      $display("[TB] randomized reads");
      for (int n = 0; n < 150; n++) begin
         rAddr = 24'h100000 + 24'($urandom_range(0, 47) * 4) + 24'($urandom_range(0, 3));
         rLat  = int'($urandom_range(0, 6));
         rFa   = ($urandom_range(0, 9) == 0);
         rFm   = ($urandom_range(0, 9) == 0);
         applyStimulus(rAddr, rLat, rFa, rFm, modelPredict(rAddr, rFa));
      end

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule

// File: doc/spimem_cache.md
Name: spimem_cache

Overview:
- Direct-mapped, word-granular, read-only cache between the CPU native memory bus and spimemio.
- Serves repeated fetches of flash code and rodata without a full SPI read transaction.
- Upstream side mirrors spimemio's valid/ready/addr/rdata port, so it drops in front of it in top unchanged.
- Downstream side drives spimemio directly.

Parameters:
- ENTRIES, 64, number of cached 32-bit words; power of 2, minimum 2.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  single-cycle pulse; invalidates all entries
- cpu_valid  in  1  request from CPU (flash region decode already applied)
- cpu_ready  out  1  one-cycle pulse; cpu_rdata valid this cycle
- cpu_addr  in  24  byte address into flash
- cpu_rdata  out  32  read data
- mem_valid  out  1  request to spimemio
- mem_ready  in  1  spimemio completion pulse
- mem_addr  out  24  word-aligned flash address
- mem_rdata  in  32  spimemio read data
- hit_count  out  32  present only with SPIMEM_CACHE_STATS_EN
- miss_count  out  32  present only with SPIMEM_CACHE_STATS_EN

Behaviour:
- Reset (async, active-high) clears the following to 0: cpu_ready, cpu_rdata, mem_valid, mem_addr, all valid bits, and counters. State returns to IDLE.
- Address split:
  - cpu_addr[1:0] is ignored.
  - index = cpu_addr[IDX_W+1:2].
  - tag = cpu_addr[23:IDX_W+2].
- Handshake:
  - CPU holds cpu_valid and cpu_addr stable until cpu_ready.
  - A request is accepted only when cpu_valid && !cpu_ready. The cycle carrying cpu_ready never starts a new lookup.
- States are IDLE and FETCH.
- IDLE, request accepted, hit (valid bit set, tag matches, flush low):
  - Next cycle: cpu_ready=1 and cpu_rdata=array data. Hit latency is 1 cycle.
- IDLE, request accepted, miss:
  - Next cycle: mem_valid=1, mem_addr={cpu_addr[23:2],2'b00}, state goes to FETCH.
- FETCH:
  - mem_valid stays high until mem_ready.
  - On the mem_ready cycle: write mem_rdata and tag into the entry, set its valid bit, latch mem_rdata into cpu_rdata.
  - Next cycle: cpu_ready=1, mem_valid=0, state returns to IDLE.
  - Miss latency is spimemio latency + 2 cycles.
- cpu_ready is high for exactly one cycle. cpu_rdata holds its value until the next response.
- Flush:
  - Clears all valid bits at the next edge.
  - A flush in the same cycle as an IDLE lookup forces a miss.
  - A flush during FETCH (including the mem_ready cycle) still returns the fetched data to the CPU, but leaves that entry invalid.
- Conflict replacement: the new tag overwrites the old entry unconditionally. No write path exists; flash is read-only.
- cpu_valid dropping without cpu_ready is illegal. In that case the block still completes any FETCH it has started.
- Reset during FETCH drops mem_valid immediately. spimemio shares the same reset and aborts its transaction with it.

Optional Feature:
- Macro: SPIMEM_CACHE_STATS_EN.
- Defined:
  - hit_count increments by 1 on each accepted hit.
  - miss_count increments by 1 on each FETCH completion.
  - Both are 32-bit, wrap at 2^32, and are not cleared by flush.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package spimem_cache_pkg holds:
  - ADDR_W=24, DATA_W=32.
  - State enum {IDLE, FETCH}.
  - Index/tag split helper functions.
- Sub-module spimem_cache_array:
  - Tag/data storage, synchronous write, combinational read, per-entry valid bits.
  - flush clear input.
- FSM and handshakes stay in the top module.

Test Plan (ENTRIES=16):
- Cold read 0x100000, spimemio answers 0xDEADBEEF after 40 cycles -> one mem_valid transaction with mem_addr 0x100000; cpu_ready one cycle after mem_ready with 0xDEADBEEF; miss_count=1.
- Re-read 0x100000 and 0x100002 -> no mem_valid; each cpu_ready 1 cycle after acceptance with 0xDEADBEEF; hit_count=2.
- Conflict: read 0x100040 (same index 0, different tag) then 0x100000 -> two misses, each fetched from spimemio; each returns its own data.
- Flush pulse, then read 0x100040 -> miss. Then flush asserted during the FETCH of 0x100080 -> data returned, but the next read of 0x100080 misses again.
- Flush in the same cycle as cpu_valid for cached 0x100040 -> treated as a miss; mem_valid asserted.
- Reset asserted mid-FETCH -> mem_valid, cpu_ready, and counters go to 0 immediately. After release, a read of 0x100040 misses.
